// File: rtl/alu4_pkg.sv
// Shared constants and types for the 4-bit ALU command sequencer.
// Commands are packed as {sel, b, a} throughout the queue and issue path.
package alu4_pkg;

   localparam int DATA_W = 4;
   localparam int CMD_W  = 2*DATA_W + 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic [1:0]        sel;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] a;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; no write-to-read bypass,
// so a pushed entry becomes visible at the head only after the push edge.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; validity is tracked by level alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/alu4_cmd_seq.sv
// Command sequencer for an external combinational 4-bit ALU:
// FIFO -> issue register (drives ALU) -> response register, with ready/valid on both ends.
module alu4_cmd_seq
   import alu4_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [DATA_W-1:0]      cmd_a,
   input  logic [DATA_W-1:0]      cmd_b,
   input  logic [1:0]             cmd_sel,
   output logic [DATA_W-1:0]      alu_a,
   output logic [DATA_W-1:0]      alu_b,
   output logic [1:0]             alu_sel,
   input  logic [DATA_W-1:0]      alu_result,
   input  logic                   alu_carry,
   input  logic                   alu_zero,
   input  logic                   alu_overflow,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_result,
   output logic                   rsp_carry,
   output logic                   rsp_zero,
   output logic                   rsp_overflow,
   output logic [7:0]             ovf_cnt,
   output logic [$clog2(DEPTH):0] fifo_level
);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   cmd_t wr_cmd;
   cmd_t head;
   logic fifo_full;
   logic fifo_empty;
   logic issue_valid;
   logic issue_load;
   logic rsp_load;

   assign wr_cmd     = '{sel: cmd_sel, b: cmd_b, a: cmd_a};
   assign cmd_ready  = ~fifo_full;
   assign rsp_load   = issue_valid & (~rsp_valid | rsp_ready);
   assign issue_load = ~fifo_empty & (~issue_valid | rsp_load);

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .wdata (wr_cmd),
      .pop   (issue_load),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Issue stage: operands only change on a new pop, keeping the ALU inputs stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= 2'b00;
      end else if (issue_load) begin
         issue_valid <= 1'b1;
         alu_a       <= head.a;
         alu_b       <= head.b;
         alu_sel     <= head.sel;
      end else if (rsp_load) begin
         issue_valid <= 1'b0;
      end
   end

   // Response stage: captured ALU outputs hold until the consumer takes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         ovf_cnt      <= '0;
      end else if (rsp_load) begin
         rsp_valid    <= 1'b1;
         rsp_result   <= alu_result;
         rsp_carry    <= alu_carry;
         rsp_zero     <= alu_zero;
         rsp_overflow <= alu_overflow;
         if (alu_overflow) begin
            ovf_cnt <= sat_inc8(ovf_cnt);
         end
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu4_cmd_seq.sv
// Directed bench for alu4_cmd_seq with a combinational ALU model on the alu_* port.
module tb_alu4_cmd_seq;
   import alu4_pkg::*;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_a;
   logic [3:0]    cmd_b;
   logic [1:0]    cmd_sel;
   logic [3:0]    alu_a;
   logic [3:0]    alu_b;
   logic [1:0]    alu_sel;
   logic [3:0]    alu_result;
   logic          alu_carry;
   logic          alu_zero;
   logic          alu_overflow;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [3:0]    rsp_result;
   logic          rsp_carry;
   logic          rsp_zero;
   logic          rsp_overflow;
   logic [7:0]    ovf_cnt;
   logic [LW-1:0] fifo_level;
   logic [6:0]    rsp_pk;

   int n_tests = 0;
   int n_fail  = 0;

   alu4_cmd_seq #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_sel      (cmd_sel),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_carry    (alu_carry),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .ovf_cnt      (ovf_cnt),
      .fifo_level   (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {result, carry, zero, overflow}; SUB reports borrow as carry.
   function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] sel);
      logic [4:0] s;
      logic [3:0] r;
      logic       c;
      logic       v;
      s = '0;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (sel)
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[3:0];
            c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
         end
         OP_SUB: begin
            r = a - b;
            c = (a < b);
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         OP_AND:  r = a & b;
         default: r = a | b;
      endcase
      return {r, c, (r == 4'd0), v};
   endfunction

   always_comb {alu_result, alu_carry, alu_zero, alu_overflow} = alu_model(alu_a, alu_b, alu_sel);
   assign rsp_pk = {rsp_result, rsp_carry, rsp_zero, rsp_overflow};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = s;
      cmd_valid = 1'b1;
      chk("send_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic apply_reset();
      cmd_valid = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   logic [3:0] t38_a   [6] = '{4'd1, 4'd9, 4'd12, 4'd10, 4'd15, 4'd3};
   logic [3:0] t38_b   [6] = '{4'd2, 4'd3, 4'd10, 4'd2,  4'd1,  4'd3};
   logic [1:0] t38_s   [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
   logic [6:0] t38_exp [6] = '{7'b0011_0_0_0, 7'b0110_0_0_1, 7'b1000_0_0_0,
                               7'b1010_0_0_0, 7'b0000_1_1_0, 7'b0000_0_1_0};

   initial begin
      logic [6:0] q[$];
      logic [3:0] ra;
      logic [3:0] rb;
      logic [1:0] rs;
      logic       acc;
      int         sent;
      int         got;
      int         first;
      int         last;
      int         stall;
      int         stale;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b1;
      #12;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
      chk("rst_rsp", rsp_pk, 0);
      chk("rst_ovf", ovf_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single ADD 7+9: latency and flags.
      send(4'd7, 4'd9, 2'b00);
      chk("lat_e0_valid", rsp_valid, 0);
      chk("lat_e0_level", fifo_level, 1);
      tick();
      chk("lat_e1_alu", {alu_a, alu_b, alu_sel}, {4'd7, 4'd9, 2'b00});
      chk("lat_e1_valid", rsp_valid, 0);
      chk("lat_e1_level", fifo_level, 0);
      tick();
      chk("lat_e2_valid", rsp_valid, 1);
      chk("add_7_9", rsp_pk, 7'b0000_1_1_0);
      tick();
      chk("add_drained", rsp_valid, 0);

      // SUB 2-5, then overflowing ADD 4+4.
      send(4'd2, 4'd5, 2'b01);
      tick(); tick();
      chk("sub_2_5", rsp_pk, 7'b1101_1_0_0);
      chk("sub_ovf_cnt", ovf_cnt, 0);
      send(4'd4, 4'd4, 2'b00);
      tick(); tick();
      chk("add_4_4", rsp_pk, 7'b1000_0_0_1);
      chk("add_ovf_cnt", ovf_cnt, 1);
      tick();

      // Back-pressure: six accepted, seventh refused, outputs held.
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(t38_a[i], t38_b[i], t38_s[i]);
      end
      cmd_a = 4'd1; cmd_b = 4'd1; cmd_sel = 2'b00; cmd_valid = 1'b1;
      chk("bp_ready_low", cmd_ready, 0);
      chk("bp_level_full", fifo_level, 4);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_head", rsp_pk, t38_exp[0]);
      repeat (3) tick();
      chk("bp_rsp_hold", rsp_pk, t38_exp[0]);
      chk("bp_alu_hold", {alu_a, alu_b, alu_sel}, {4'd9, 4'd3, 2'b01});
      chk("bp_level_hold", fifo_level, 4);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("bp_order_valid", rsp_valid, 1);
         chk($sformatf("bp_order_%0d", k), rsp_pk, t38_exp[k]);
         tick();
      end
      chk("bp_no_extra", rsp_valid, 0);

      // Sixteen random commands back to back.
      q.delete();
      sent = 0; got = 0; first = -1; last = -1; stall = 0;
      for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
         if (sent < 16) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
            cmd_a = ra; cmd_b = rb; cmd_sel = rs; cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         acc = cmd_valid && cmd_ready;
         if (cmd_valid && !cmd_ready) stall++;
         tick();
         if (acc) begin
            q.push_back(alu_model(ra, rb, rs));
            sent++;
         end
         if (rsp_valid) begin
            if (q.size() == 0) chk("rnd_extra", 1, 0);
            else chk("rnd_data", rsp_pk, q.pop_front());
            if (got == 0) first = cyc;
            last = cyc;
            got++;
         end
      end
      cmd_valid = 1'b0;
      chk("rnd_count", got, 16);
      chk("rnd_span", last - first, 15);
      chk("rnd_stall", stall, 0);

      // Overflow counter saturation.
      apply_reset();
      chk("sat_start", ovf_cnt, 0);
      cmd_a = 4'd4; cmd_b = 4'd4; cmd_sel = 2'b00;
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 400 && got < 300; cyc++) begin
         cmd_valid = (sent < 300);
         acc = cmd_valid && cmd_ready;
         tick();
         if (acc) sent++;
         if (rsp_valid) begin
            got++;
            if (got == 100) chk("sat_mid", ovf_cnt, 100);
            if (got == 255) chk("sat_255", ovf_cnt, 255);
         end
      end
      cmd_valid = 1'b0;
      chk("sat_count", got, 300);
      chk("sat_final", ovf_cnt, 255);

      // Asynchronous reset with commands in flight.
      rsp_ready = 1'b0;
      send(4'd3, 4'd5, 2'b00);
      send(4'd6, 4'd2, 2'b11);
      send(4'd7, 4'd7, 2'b10);
      chk("ar_inflight", rsp_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_rsp_valid", rsp_valid, 0);
      chk("ar_level", fifo_level, 0);
      chk("ar_alu", {alu_a, alu_b, alu_sel}, 0);
      chk("ar_rsp", rsp_pk, 0);
      chk("ar_ovf", ovf_cnt, 0);
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      chk("ar_ready_after", cmd_ready, 1);
      stale = 0;
      repeat (6) begin
         tick();
         if (rsp_valid) stale++;
      end
      chk("ar_no_stale", stale, 0);
      chk("ar_level_after", fifo_level, 0);
      send(4'd5, 4'd1, 2'b01);
      tick(); tick();
      chk("ar_fresh", rsp_pk, 7'b0100_0_0_0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
